// File: rtl/uart_rx_core.sv
// uart_rx_core
//   Baud-tick generator plus odd-parity frame receiver. A complete 11-bit frame
//   word is presented in parallel on out_tx. The receiver latches it on the
//   first receive tick that shows a start bit. It then consumes one latched bit
//   per receive tick and publishes the data byte when parity and stop both check.
//
// State table:
//   state | meaning
//   IDLE  | waiting for an inrx strobe with out_tx[0] = 0
//   RECV  | consuming latched bits 1..10, one per inrx strobe
//   CHECK | single cycle, result flags are visible
//   HOLD  | waiting for out_tx to differ from the latched frame
//
// Parameters
//   CLK_FREQ    system clock frequency in Hz
//   OVERSAMPLE  receive-tick rate as a multiple of the baud rate
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   baud_sel    00=9600 01=115200 10=460800 11=921600
//   out_tx      frame word: [0] start, [8:1] data (LSB at 1), [9] odd parity, [10] stop
//   intx        one-clk strobe at the baud rate
//   inrx        one-clk strobe at baud x OVERSAMPLE
//   out_rx      last valid received byte
//   rx_valid    one-clk pulse when out_rx is updated
//   parity_err  one-clk pulse on an odd-parity failure
//   frame_err   one-clk pulse when the stop bit is 0
module uart_rx_core #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int OVERSAMPLE = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  baud_sel,
  input  logic [10:0] out_tx,
  output logic        intx,
  output logic        inrx,
  output logic [7:0]  out_rx,
  output logic        rx_valid,
  output logic        parity_err,
  output logic        frame_err
);

  localparam int BAUD_0 = 9600;
  localparam int BAUD_1 = 115200;
  localparam int BAUD_2 = 460800;
  localparam int BAUD_3 = 921600;

  // Divisors rounded to nearest.
  localparam int DIV_TX_0 = (CLK_FREQ + BAUD_0 / 2) / BAUD_0;
  localparam int DIV_TX_1 = (CLK_FREQ + BAUD_1 / 2) / BAUD_1;
  localparam int DIV_TX_2 = (CLK_FREQ + BAUD_2 / 2) / BAUD_2;
  localparam int DIV_TX_3 = (CLK_FREQ + BAUD_3 / 2) / BAUD_3;
  localparam int DIV_RX_0 = (CLK_FREQ + (BAUD_0 * OVERSAMPLE) / 2) / (BAUD_0 * OVERSAMPLE);
  localparam int DIV_RX_1 = (CLK_FREQ + (BAUD_1 * OVERSAMPLE) / 2) / (BAUD_1 * OVERSAMPLE);
  localparam int DIV_RX_2 = (CLK_FREQ + (BAUD_2 * OVERSAMPLE) / 2) / (BAUD_2 * OVERSAMPLE);
  localparam int DIV_RX_3 = (CLK_FREQ + (BAUD_3 * OVERSAMPLE) / 2) / (BAUD_3 * OVERSAMPLE);

  // The slowest baud has the largest divisor, so it sizes the counters.
  localparam int TX_W = $clog2(DIV_TX_0 + 1);
  localparam int RX_W = $clog2(DIV_RX_0 + 1);

  localparam logic [TX_W-1:0] TX_LAST_0 = TX_W'(DIV_TX_0 - 1);
  localparam logic [TX_W-1:0] TX_LAST_1 = TX_W'(DIV_TX_1 - 1);
  localparam logic [TX_W-1:0] TX_LAST_2 = TX_W'(DIV_TX_2 - 1);
  localparam logic [TX_W-1:0] TX_LAST_3 = TX_W'(DIV_TX_3 - 1);
  localparam logic [RX_W-1:0] RX_LAST_0 = RX_W'(DIV_RX_0 - 1);
  localparam logic [RX_W-1:0] RX_LAST_1 = RX_W'(DIV_RX_1 - 1);
  localparam logic [RX_W-1:0] RX_LAST_2 = RX_W'(DIV_RX_2 - 1);
  localparam logic [RX_W-1:0] RX_LAST_3 = RX_W'(DIV_RX_3 - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Tick generators
  // ---------------------------------------------------------------------------
  logic [1:0]      baud_sel_q;
  logic [TX_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [RX_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [TX_W-1:0] tx_last;
  logic [RX_W-1:0] rx_last;
  logic            baud_chg;
  logic            tx_tick;
  logic            rx_tick;

  always_comb begin
    tx_last = TX_LAST_0;
    rx_last = RX_LAST_0;
    case (baud_sel)
      2'b00: begin tx_last = TX_LAST_0; rx_last = RX_LAST_0; end
      2'b01: begin tx_last = TX_LAST_1; rx_last = RX_LAST_1; end
      2'b10: begin tx_last = TX_LAST_2; rx_last = RX_LAST_2; end
      default: begin tx_last = TX_LAST_3; rx_last = RX_LAST_3; end
    endcase
  end

  // On the cycle baud_sel changes, the counter still holds a count from the old
  // rate. The strobe is suppressed there so it never compares against the new limit.
  assign baud_chg = (baud_sel != baud_sel_q);
  assign tx_tick  = (tx_cnt_q == tx_last) && !baud_chg;
  assign rx_tick  = (rx_cnt_q == rx_last) && !baud_chg;

  always_comb begin
    tx_cnt_d = tx_cnt_q + TX_W'(1);
    rx_cnt_d = rx_cnt_q + RX_W'(1);
    if (baud_chg || tx_tick) tx_cnt_d = '0;
    if (baud_chg || rx_tick) rx_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_sel_q <= 2'b00;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
    end else begin
      baud_sel_q <= baud_sel;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
    end
  end

  assign intx = tx_tick;
  assign inrx = rx_tick;

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [10:0] frame_q, frame_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  data_q, data_d;
  logic        par_q, par_d;
  logic        stop_q, stop_d;
  logic [7:0]  out_rx_q, out_rx_d;
  logic        rx_valid_q, rx_valid_d;
  logic        parity_err_q, parity_err_d;
  logic        frame_err_q, frame_err_d;
  logic        parity_ok;
  logic        stop_ok;

  // Evaluated on the strobe that consumes the stop bit. Data and parity are
  // already complete, and the stop bit is taken straight from the frame. This
  // registers the result flags on that edge, so they are high during CHECK and
  // are visible one clk after the strobe.
  assign parity_ok = ^{data_q, par_q};
  assign stop_ok   = frame_q[10];

  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    bit_cnt_d    = bit_cnt_q;
    data_d       = data_q;
    par_d        = par_q;
    stop_d       = stop_q;
    out_rx_d     = out_rx_q;
    rx_valid_d   = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_tick && !out_tx[0]) begin
          frame_d   = out_tx;
          bit_cnt_d = 4'd1;
          state_d   = RECV;
        end
      end

      RECV: begin
        if (rx_tick) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q <= 4'd8) begin
            // LSB first: shift right, so bit 1 ends in data[0] after 8 shifts.
            data_d = {frame_q[bit_cnt_q], data_q[7:1]};
          end else if (bit_cnt_q == 4'd9) begin
            par_d = frame_q[9];
          end else begin
            stop_d  = frame_q[10];
            state_d = CHECK;
            if (parity_ok && stop_ok) begin
              out_rx_d   = data_q;
              rx_valid_d = 1'b1;
            end else begin
              parity_err_d = !parity_ok;
              frame_err_d  = !stop_ok;
            end
          end
        end
      end

      CHECK: begin
        state_d = HOLD;
      end

      HOLD: begin
        // A static frame word must produce only one reception.
        if (out_tx != frame_q) begin
          state_d   = IDLE;
          bit_cnt_d = 4'd0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      frame_q      <= '0;
      bit_cnt_q    <= '0;
      data_q       <= '0;
      par_q        <= 1'b0;
      stop_q       <= 1'b0;
      out_rx_q     <= 8'h00;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      bit_cnt_q    <= bit_cnt_d;
      data_q       <= data_d;
      par_q        <= par_d;
      stop_q       <= stop_d;
      out_rx_q     <= out_rx_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign out_rx     = out_rx_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;

  logic        clk;
  logic        reset_n;
  logic [1:0]  baud_sel;
  logic [10:0] out_tx;
  logic        intx;
  logic        inrx;
  logic [7:0]  out_rx;
  logic        rx_valid;
  logic        parity_err;
  logic        frame_err;

  uart_rx_core #(
    .CLK_FREQ  (100_000_000),
    .OVERSAMPLE(16)
  ) dut (
    .clk       (clk),
    .reset     (reset_n),
    .baud_sel  (baud_sel),
    .out_tx    (out_tx),
    .intx      (intx),
    .inrx      (inrx),
    .out_rx    (out_rx),
    .rx_valid  (rx_valid),
    .parity_err(parity_err),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       p;
    logic       f;
    logic [7:0] d;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Monitor: every cycle with a result flag consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (rx_valid || parity_err || frame_err) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_flag: got v=%0b p=%0b f=%0b out_rx=0x%0h, expected no flag",
                 rx_valid, parity_err, frame_err, out_rx);
      end else begin
        e = exp_q.pop_front();
        check("flags", int'({rx_valid, parity_err, frame_err}), int'({e.v, e.p, e.f}));
        check("out_rx_at_flag", int'(out_rx), int'(e.d));
      end
    end
  end

  task automatic measure(input bit use_tx, output int period, output int width);
    int t, r1, r2, w;
    bit prev, s;
    t = 0; r1 = -1; r2 = -1; w = 0; prev = 1'b1;
    while (r2 < 0 && t < 1000) begin
      @(negedge clk);
      t++;
      s = use_tx ? intx : inrx;
      if (s && !prev) begin
        if (r1 < 0) r1 = t;
        else r2 = t;
      end
      if (s && r1 >= 0 && r2 < 0) w++;
      prev = s;
    end
    period = (r2 < 0) ? -1 : r2 - r1;
    width  = w;
  endtask

  // Drives a frame word from IDLE, checks start-strobe to flag latency, holds
  // the word (monitor catches any repeat pulse), then returns to idle.
  task automatic run_frame(input string name, input logic [10:0] w,
                           input logic ev, input logic ep, input logic ef);
    exp_t e;
    int t, s_t, f_t;
    e.v = ev; e.p = ep; e.f = ef;
    if (ev) last_good = w[8:1];
    e.d = last_good;
    exp_q.push_back(e);
    @(posedge clk); #1 out_tx = w;
    t = 0; s_t = -1; f_t = -1;
    while (f_t < 0 && t < 3000) begin
      @(negedge clk);
      t++;
      if (s_t < 0 && inrx) s_t = t;
      if (rx_valid || parity_err || frame_err) f_t = t;
    end
    check({name, "_latency"}, (f_t < 0 || s_t < 0) ? -1 : f_t - s_t, 141);
    repeat (400) @(negedge clk);
    @(posedge clk); #1 out_tx = 11'h7FF;
    repeat (20) @(negedge clk);
  endtask

  task automatic no_start(input string name, input logic [10:0] w);
    @(posedge clk); #1 out_tx = w;
    repeat (400) @(negedge clk);
    check({name, "_out_rx"}, int'(out_rx), int'(last_good));
  endtask

  initial begin
    int per, wid;
    reset_n  = 1'b0;
    baud_sel = 2'b10;
    out_tx   = 11'h7FF;

    repeat (3) @(negedge clk);
    check("reset_outputs", int'({intx, inrx, out_rx, rx_valid, parity_err, frame_err}), 0);
    @(posedge clk); #1 reset_n = 1'b1;

    measure(1'b0, per, wid);
    check("inrx_period_460800", per, 14);
    check("inrx_width", wid, 1);
    measure(1'b1, per, wid);
    check("intx_period_460800", per, 217);
    check("intx_width", wid, 1);

    run_frame("valid_55", 11'b11010101010, 1'b1, 1'b0, 1'b0);
    check("out_rx_55", int'(out_rx), 8'h55);
    run_frame("parity_aa", 11'b10101010100, 1'b0, 1'b1, 1'b0);
    check("out_rx_kept_55", int'(out_rx), 8'h55);
    no_start("start1_a", 11'b11111000001);
    no_start("start1_b", 11'b11100110001);
    run_frame("parity_1e", 11'b10000111100, 1'b0, 1'b1, 1'b0);
    run_frame("frame_err", 11'b01010101010, 1'b0, 1'b0, 1'b1);
    run_frame("both_err", 11'b01000000010, 1'b0, 1'b1, 1'b1);
    run_frame("valid_3c", 11'b11001111000, 1'b1, 1'b0, 1'b0);
    check("out_rx_3c", int'(out_rx), 8'h3C);

    // Reset in the middle of reception.
    @(posedge clk); #1 out_tx = 11'b11010101010;
    repeat (60) @(negedge clk);
    @(posedge clk); #1 reset_n = 1'b0;
    @(negedge clk);
    check("midframe_reset_outputs", int'({out_rx, rx_valid, parity_err, frame_err}), 0);
    out_tx = 11'h7FF;
    repeat (5) @(negedge clk);
    @(posedge clk); #1 reset_n = 1'b1;
    last_good = 8'h00;
    repeat (300) @(negedge clk);
    check("out_rx_after_reset", int'(out_rx), 0);

    @(posedge clk); #1 baud_sel = 2'b11;
    measure(1'b0, per, wid);
    check("inrx_period_921600", per, 7);
    measure(1'b1, per, wid);
    check("intx_period_921600", per, 109);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Baud-tick generator plus parity-checking frame receiver for the UART receive path. It takes an 11-bit frame word presented in parallel on `out_tx`. It consumes one frame bit per receive tick, checks odd parity and the stop bit, and publishes valid data bytes on `out_rx`. Transmit-rate and receive-rate tick strobes are also exported for the transmitter side.

## Interface
- `CLK_FREQ`, 100_000_000, system clock frequency in Hz.
- `OVERSAMPLE`, 16, receive-tick rate as a multiple of the baud rate.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `baud_sel`  in  2  baud rate select:
  - 00 = 9600
  - 01 = 115200
  - 10 = 460800
  - 11 = 921600
- `out_tx`  in  11  frame word:
  - [0] start bit, 0 = start
  - [8:1] data, bit 1 = data LSB
  - [9] odd parity
  - [10] stop bit, must be 1
  - Idle is all 1s.
- `intx`  out  1  one-clk strobe at the baud rate.
- `inrx`  out  1  one-clk strobe at baud × OVERSAMPLE.
- `out_rx`  out  8  last valid received byte.
- `rx_valid`  out  1  one-clk pulse when `out_rx` is updated.
- `parity_err`  out  1  one-clk pulse when a frame fails the odd-parity check.
- `frame_err`  out  1  one-clk pulse when a frame has stop bit 0.

## Operation
- Divisors are rounded to nearest: DIV_TX = (CLK_FREQ + B/2)/B and DIV_RX = (CLK_FREQ + B·OVERSAMPLE/2)/(B·OVERSAMPLE). At 100 MHz:
  - 9600: DIV_TX 10417, DIV_RX 651
  - 115200: DIV_TX 868, DIV_RX 54
  - 460800: DIV_TX 217, DIV_RX 14
  - 921600: DIV_TX 109, DIV_RX 7
- Each tick has its own counter running 0..DIV−1. The strobe is high for exactly the one clk where counter = DIV−1, and the counter then wraps to 0.
- A change of `baud_sel` clears both counters on the next clk.
- The receiver FSM has four states: IDLE, RECV, CHECK, HOLD.
- IDLE:
  - On an `inrx` strobe with `out_tx[0]`=0, latch the full `out_tx` into the frame register, set bit_cnt=1 and go to RECV.
  - If `out_tx[0]`=1, stay in IDLE; no frame is ever started.
- RECV:
  - Each `inrx` strobe shifts one latched bit into the data/parity/stop registers and increments bit_cnt.
  - When bit 10 (stop) is consumed, go to CHECK.
  - `out_tx` changes during RECV are ignored, because the frame was latched.
- CHECK, one clk:
  - parity_ok = XOR of data[7:0] and the parity bit equals 1 (odd parity).
  - stop_ok = stop bit equals 1.
  - If both are ok: `out_rx`←data and `rx_valid`=1.
  - Otherwise `out_rx` is unchanged. `parity_err`=!parity_ok and `frame_err`=!stop_ok; both may pulse together.
  - Then go to HOLD.
- HOLD: stay until `out_tx` differs from the latched frame, then return to IDLE on the next clk. A frame word held static therefore yields exactly one reception.
- Reset forces the tick counters to 0, the FSM to IDLE, bit_cnt to 0 and all outputs low; `out_rx` resets to 0x00.
- Reset asserted mid-frame aborts the frame with no flags.

## Timing
- Tick period is DIV clk cycles. At `baud_sel`=10 and 100 MHz, `inrx` strikes every 14 clk (140 ns) and `intx` every 217 clk (2.17 µs).
- Start detect occurs at the first `inrx` strobe with `out_tx[0]`=0. Bits 1..10 are consumed on the following 10 strobes.
- `rx_valid`/`parity_err`/`frame_err` assert 1 clk after the strobe that consumes the stop bit.
- Total latency from the start strobe to the flag pulse is 10·DIV_RX + 1 clk (≈1.41 µs at 460800).
- Flags are single-cycle. `out_rx` holds its value until the next valid frame or reset.
- If a strobe coincides with the return to IDLE, it is not used for start detection; detection begins with the next strobe.

## Test plan
- `baud_sel`=10 with reset released → `inrx` period of 14 clk and `intx` period of 217 clk; both strobes exactly 1 clk wide; all outputs 0 during reset.
- `out_tx`=11'b11010101010 → after ~1.41 µs, `out_rx`=0x55 with a single `rx_valid` pulse and no errors; holding the word produces no second pulse.
- `out_tx`=11'b10101010100 (data 0xAA, parity 0) → `parity_err` pulses once; `out_rx` stays 0x55; `rx_valid` stays 0.
- `out_tx`=11'b11111000001, then 11'b11100110001 (start bit 1) → no activity; FSM stays in IDLE; `out_rx` is unchanged.
- `out_tx`=11'b10000111100 (data 0x1E, parity 0) → `parity_err` pulses once.
- `out_tx`=11'b01010101010 (valid parity, stop bit 0) → `frame_err` only.
- Assert `reset` low mid-RECV → immediate return to IDLE, `out_rx`=0x00, no flags.
- Change `baud_sel` to 11 → `inrx` period of 7 clk and `intx` period of 109 clk.
